piso_serializer: RTL
====================

# piso_serializer

Parametrised parallel-in/serial-out serializer with a one-word holding buffer, a valid/ready load handshake, a per-bit advance enable and a selectable bit order. It sits between a parallel word producer and a single-wire serial link. Because the holding buffer accepts the next word while the current one is shifting, consecutive words go out back-to-back with no idle bit between them. A per-bit strobe, a busy level and an end-of-word pulse are provided for the downstream framer.

## Interface
- `WIDTH`, default 12: bits per word. Legal range is 2 or more.
- `LSB_FIRST`, default 1: 1 sends bit 0 first; 0 sends bit WIDTH-1 first.
- `IDLE_LEVEL`, default 0: level driven on `data_out` when no word is active.
- `CLK`, in, 1: the single clock; all state changes on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `data_in`, in, WIDTH: parallel word, sampled when `load && ready`.
- `load`, in, 1: word-valid request.
- `ready`, out, 1: holding buffer empty; combinational, `ready = !hold_v`.
- `send`, in, 1: bit-advance enable; one bit is emitted per rising edge where `send=1`.
- `data_out`, out, 1: registered serial output.
- `frame`, out, 1: registered; high for the cycle after each bit is emitted (bit strobe).
- `done`, out, 1: registered one-cycle pulse, coincident with the last bit of a word.
- `busy`, out, 1: `active | hold_v`.
- `overrun`, out, 1: registered one-cycle pulse when `load` is asserted while `ready=0`.

## Operation
- Internal state:
  - `hold_q[WIDTH]` and `hold_v`: holding buffer.
  - `shreg[WIDTH]` and `active`: shifter.
  - `cnt[$clog2(WIDTH)]`: bit index.
- Reset values (async, `rst_n=0`): `hold_v=0`, `active=0`, `cnt=0`, `data_out=IDLE_LEVEL`, `frame=0`, `done=0`, `overrun=0`. As a result, `ready=1` and `busy=0`. `hold_q` and `shreg` also clear to 0.
- Load:
  - `load && ready` at an edge: `hold_q<=data_in`, `hold_v<=1`.
  - `load && !ready`: the word is dropped, `hold_q` is unchanged, and `overrun<=1` for one cycle.
- Transfer: at an edge with `active=0 && hold_v=1`, `shreg<=hold_q`, `cnt<=0`, `active<=1`, `hold_v<=0`. No bit is emitted on the transfer edge, even if `send=1`.
- States:
  - IDLE: `!active`, `!hold_v`.
  - PENDING: `!active`, `hold_v`. Always lasts exactly one cycle.
  - SHIFT: `active`, with `hold_v` either 0 or 1.
- Bit emission, at an edge with `active && send`:
  - `data_out <= shreg[cnt]` when `LSB_FIRST=1`, or `shreg[WIDTH-1-cnt]` when `LSB_FIRST=0`.
  - `frame<=1`.
  - If `cnt!=WIDTH-1`: `cnt<=cnt+1`.
  - If `cnt==WIDTH-1`: `done<=1`. Then:
    - If `hold_v=1`: `shreg<=hold_q`, `cnt<=0`, `hold_v<=0`, and `active` stays 1 (seamless chaining).
    - Otherwise: `active<=0`.
- `active && !send`: `frame<=0`, `data_out` holds the last emitted bit, `cnt` holds.
- `!active` and no emission: `data_out<=IDLE_LEVEL`, `frame<=0`, `done<=0`.
- Simultaneous events:
  - A load in the same edge as a last-bit chaining: cannot occur, because `ready=0` whenever `hold_v=1`.
  - A load in the same edge as the IDLE→SHIFT transfer: cannot occur either, because `hold_v=1` at that edge. `ready` rises the cycle after the transfer.
- `cnt` never exceeds WIDTH-1. No wrap-around occurs other than the reset to 0 on chaining or transfer.
- Reset mid-word: the word in flight and the buffered word are discarded. `data_out` returns to `IDLE_LEVEL` immediately (async).

## Timing
- Load accepted at edge N.
- Transfer at edge N+1.
- The first `send` edge at or after N+2 emits bit 0 of the word. `data_out` is valid from that edge onward.
- Minimum word time is WIDTH `send` edges. With `send` held high and the buffer refilled in time, the output is a continuous bitstream: word k's last bit is at edge M and word k+1's first bit is at edge M+1.
- `ready` returns high one cycle after the transfer or chaining edge.
- `done` is asserted for exactly one cycle, after the edge emitting bit WIDTH-1.
- `overrun` is asserted for one cycle after the offending edge.
- `busy` and `ready` are combinational from registers and have no combinational path from inputs.

## Test plan
- Reset/idle: assert `rst_n=0` mid-word, then release. Required: `data_out=0`, `frame=0`, `busy=0`, `ready=1`. No further bits appear until a new load.
- LSB-first word (WIDTH=12): load 12'hA5C, hold `send=1`. Required: bits 0,0,1,1,1,0,1,0,0,1,0,1 on 12 consecutive edges starting at N+2, with `done` on the 12th edge, then `busy=0` and `data_out=0`.
- MSB-first (`LSB_FIRST=0`): load 12'hA5C. Required: bits 1,0,1,0,0,1,0,1,1,1,0,0.
- Back-to-back: load 12'hFFF, then load 12'h000 as soon as `ready` rises, with `send=1` throughout. Required: 12 ones immediately followed by 12 zeros, no gap, and two `done` pulses 12 cycles apart.
- Gapped `send`: toggle `send` 1,0,1,0. Required: one bit per `send=1` edge, `data_out` held and `frame=0` during `send=0`, and `done` after the 12th enabled edge.
- Overrun: while `hold_v=1`, assert `load` with 12'h123. Required: `overrun` pulses for one cycle, and the buffered word, not 12'h123, is transmitted next.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a one-word holding buffer so that
// consecutive words leave back-to-back on the serial link.
module piso_serializer #(
  parameter int unsigned WIDTH      = 12,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  input  logic             send,
  output logic             data_out,
  output logic             frame,
  output logic             done,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] hold_q, hold_q_nxt;
  logic             hold_v, hold_v_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             data_out_nxt;
  logic             frame_nxt;
  logic             done_nxt;
  logic             overrun_nxt;
  logic [CW-1:0]    idx;
  logic             active;

  assign active = (state == ST_SHIFT);
  assign ready  = ~hold_v;
  assign busy   = active | hold_v;

  // Bit order is fixed at elaboration; index walks up or down the shifter.
  assign idx = LSB_FIRST ? cnt : (LAST - cnt);

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state;
    hold_q_nxt   = hold_q;
    hold_v_nxt   = hold_v;
    shreg_nxt    = shreg;
    cnt_nxt      = cnt;
    data_out_nxt = data_out;
    frame_nxt    = 1'b0;
    done_nxt     = 1'b0;
    overrun_nxt  = load & hold_v;

    if (load && !hold_v) begin
      hold_q_nxt = data_in;
      hold_v_nxt = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        data_out_nxt = IDLE_LEVEL;
        if (hold_v_nxt) state_nxt = ST_PEND;
      end
      ST_PEND: begin
        // Buffer is full here, so no load can collide with the transfer.
        data_out_nxt = IDLE_LEVEL;
        shreg_nxt    = hold_q;
        cnt_nxt      = '0;
        hold_v_nxt   = 1'b0;
        state_nxt    = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (send) begin
          data_out_nxt = shreg[idx];
          frame_nxt    = 1'b1;
          if (cnt == LAST) begin
            done_nxt = 1'b1;
            if (hold_v) begin
              shreg_nxt  = hold_q;
              cnt_nxt    = '0;
              hold_v_nxt = 1'b0;
            end else begin
              state_nxt = hold_v_nxt ? ST_PEND : ST_IDLE;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hold_q   <= '0;
      hold_v   <= 1'b0;
      shreg    <= '0;
      cnt      <= '0;
      data_out <= IDLE_LEVEL;
      frame    <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_q   <= hold_q_nxt;
      hold_v   <= hold_v_nxt;
      shreg    <= shreg_nxt;
      cnt      <= cnt_nxt;
      data_out <= data_out_nxt;
      frame    <= frame_nxt;
      done     <= done_nxt;
      overrun  <= overrun_nxt;
    end
  end

endmodule
